vanilla_core_trigger_window: RTL and testbench

Per-core, multi-channel activity-window controller bound into each vanilla core. Decodes trigger-start/trigger-end instructions retiring from the execute stage and tracks a nesting depth per channel. It drives a per-channel window enable that the host ORs across cores and loops back as `global_en_i`. On the leader core only, it emits one-cycle toggle-start/toggle-stop pulses on global edges, which drive power-annotation collection per channel. An optional per-channel saturating active-cycle counter is included.

---
 rtl/bsg_vanilla_pkg.sv | 27 ++
 rtl/vanilla_core_trigger_window_if.sv | 27 ++
 rtl/vanilla_trigger_channel.sv | 76 +++++++
 rtl/vanilla_core_trigger_window.sv | 68 ++++++
 tb/tb_vanilla_core_trigger_window.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/bsg_vanilla_pkg.sv
// Shared trigger-instruction encodings and the decode helper for vanilla_core_trigger_window.
package bsg_vanilla_pkg;

  // Custom-0 opcode; funct3 selects start/end, the channel travels in [24:20].
  localparam logic [31:0] TRIGGER_START_PATTERN = 32'b0000000_?????_00000_000_00000_0001011;
  localparam logic [31:0] TRIGGER_END_PATTERN   = 32'b0000000_?????_00000_001_00000_0001011;

  localparam int unsigned TRIGGER_CH_HI = 24;
  localparam int unsigned TRIGGER_CH_LO = 20;

  typedef enum logic [1:0] {
    TRIG_NONE  = 2'd0,
    TRIG_START = 2'd1,
    TRIG_END   = 2'd2
  } trig_op_e;

  function automatic trig_op_e decode_trigger(input logic [31:0] instr);
    trig_op_e op;
    op = TRIG_NONE;
    if (instr ==? TRIGGER_START_PATTERN)
      op = TRIG_START;
    else if (instr ==? TRIGGER_END_PATTERN)
      op = TRIG_END;
    return op;
  endfunction

endpackage

// File: rtl/vanilla_core_trigger_window_if.sv
// Core-side bundle of vanilla_core_trigger_window: execute-stage inputs, global loopback and window outputs.
interface vanilla_core_trigger_window_if #(
  parameter int unsigned num_ch_p      = 4,
  parameter int unsigned count_width_p = 32
);
  logic [31:0]                       instr_i;
  logic                              instr_v_i;
  logic                              stall_i;
  logic                              leader_i;
  logic [num_ch_p-1:0]               global_en_i;
  logic [num_ch_p-1:0]               window_en_o;
  logic [num_ch_p-1:0]               toggle_start_o;
  logic [num_ch_p-1:0]               toggle_stop_o;
  logic [num_ch_p-1:0]               overflow_o;
  logic [num_ch_p-1:0]               underflow_o;
  logic [num_ch_p*count_width_p-1:0] active_cycles_o;

  modport master (
    output instr_i, instr_v_i, stall_i, leader_i, global_en_i,
    input  window_en_o, toggle_start_o, toggle_stop_o, overflow_o, underflow_o, active_cycles_o
  );

  modport slave (
    input  instr_i, instr_v_i, stall_i, leader_i, global_en_i,
    output window_en_o, toggle_start_o, toggle_stop_o, overflow_o, underflow_o, active_cycles_o
  );
endinterface

// File: rtl/vanilla_trigger_channel.sv
// One trigger channel: nesting depth, sticky over/underflow flags and, with
// VANILLA_TRIGGER_COUNTERS_EN defined, a saturating active-cycle counter.
module vanilla_trigger_channel
  import bsg_vanilla_pkg::*;
#(
  parameter int unsigned max_depth_p   = 3,
  parameter int unsigned count_width_p = 32
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  trig_op_e                 op_i,
  output logic                     window_en_o,
  output logic                     overflow_o,
  output logic                     underflow_o,
  output logic [count_width_p-1:0] active_cycles_o
);

  localparam int unsigned depth_width_lp = $clog2(max_depth_p + 1);
  localparam logic [depth_width_lp-1:0] max_depth_lp = depth_width_lp'(max_depth_p);

  logic [depth_width_lp-1:0] depth_q, depth_n;
  logic                      overflow_n, underflow_n;

  always_comb begin
    depth_n     = depth_q;
    overflow_n  = overflow_o;
    underflow_n = underflow_o;
    case (op_i)
      TRIG_START: begin
        if (depth_q == max_depth_lp) overflow_n = 1'b1;
        else                         depth_n    = depth_q + 1'b1;
      end
      TRIG_END: begin
        if (depth_q == '0) underflow_n = 1'b1;
        else               depth_n     = depth_q - 1'b1;
      end
      default: ;
    endcase
  end

  // window_en_o is registered from the next depth so it opens the cycle after the accept.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      depth_q     <= '0;
      window_en_o <= 1'b0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      depth_q     <= depth_n;
      window_en_o <= (depth_n != '0);
      overflow_o  <= overflow_n;
      underflow_o <= underflow_n;
    end
  end

`ifdef VANILLA_TRIGGER_COUNTERS_EN
  logic [count_width_p-1:0] count_q;
  logic                     window_open;

  assign window_open = (op_i == TRIG_START) && (depth_q == '0);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)
      count_q <= '0;
    else if (window_open)
      count_q <= '0;
    else if (window_en_o && (count_q != '1))
      count_q <= count_q + 1'b1;
  end

  assign active_cycles_o = count_q;
`else
  assign active_cycles_o = '0;
`endif

endmodule

// File: rtl/vanilla_core_trigger_window.sv
// Per-core trigger window controller: instruction decode, per-channel depth tracking and leader-only
// global edge pulses. Optional active-cycle counters are enabled by defining VANILLA_TRIGGER_COUNTERS_EN.
module vanilla_core_trigger_window
  import bsg_vanilla_pkg::*;
#(
  parameter int unsigned num_ch_p      = 4,
  parameter int unsigned max_depth_p   = 3,
  parameter int unsigned count_width_p = 32
) (
  input logic                        clk_i,
  input logic                        reset_n_i,
  vanilla_core_trigger_window_if.slave bus_if
);

  logic                                  accept;
  trig_op_e                              op;
  logic [TRIGGER_CH_HI-TRIGGER_CH_LO:0]  chan;
  logic [num_ch_p-1:0]                   window_en;
  logic [num_ch_p-1:0]                   overflow;
  logic [num_ch_p-1:0]                   underflow;
  logic [num_ch_p*count_width_p-1:0]     active_cycles;
  logic [num_ch_p-1:0]                   global_en_r;
  logic [num_ch_p-1:0]                   toggle_start_r;
  logic [num_ch_p-1:0]                   toggle_stop_r;

  assign accept = bus_if.instr_v_i & ~bus_if.stall_i;
  assign op     = decode_trigger(bus_if.instr_i);
  assign chan   = bus_if.instr_i[TRIGGER_CH_HI:TRIGGER_CH_LO];

  // Channels >= num_ch_p never match any generated index, so they are dropped here.
  for (genvar c = 0; c < num_ch_p; c++) begin : g_ch
    trig_op_e ch_op;
    assign ch_op = (accept && (chan == 5'(c))) ? op : TRIG_NONE;

    vanilla_trigger_channel #(
      .max_depth_p  (max_depth_p),
      .count_width_p(count_width_p)
    ) u_channel (
      .clk_i          (clk_i),
      .reset_n_i      (reset_n_i),
      .op_i           (ch_op),
      .window_en_o    (window_en[c]),
      .overflow_o     (overflow[c]),
      .underflow_o    (underflow[c]),
      .active_cycles_o(active_cycles[c*count_width_p +: count_width_p])
    );
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      global_en_r    <= '0;
      toggle_start_r <= '0;
      toggle_stop_r  <= '0;
    end else begin
      global_en_r    <= bus_if.global_en_i;
      toggle_start_r <= bus_if.global_en_i & ~global_en_r & {num_ch_p{bus_if.leader_i}};
      toggle_stop_r  <= ~bus_if.global_en_i & global_en_r & {num_ch_p{bus_if.leader_i}};
    end
  end

  assign bus_if.window_en_o     = window_en;
  assign bus_if.overflow_o      = overflow;
  assign bus_if.underflow_o     = underflow;
  assign bus_if.active_cycles_o = active_cycles;
  assign bus_if.toggle_start_o  = toggle_start_r;
  assign bus_if.toggle_stop_o   = toggle_stop_r;

endmodule

// File: tb/tb_vanilla_core_trigger_window.sv
// Directed bench for vanilla_core_trigger_window: two cores (A leader, B follower) share a global OR loopback.
module tb_vanilla_core_trigger_window;

  localparam int unsigned NCH = 4;
  localparam int unsigned CW  = 32;
`ifdef VANILLA_TRIGGER_COUNTERS_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  vanilla_core_trigger_window_if #(.num_ch_p(NCH), .count_width_p(CW)) ifa ();
  vanilla_core_trigger_window_if #(.num_ch_p(NCH), .count_width_p(CW)) ifb ();

  assign ifa.global_en_i = ifa.window_en_o | ifb.window_en_o;
  assign ifb.global_en_i = ifa.window_en_o | ifb.window_en_o;

  vanilla_core_trigger_window #(.num_ch_p(NCH), .max_depth_p(3), .count_width_p(CW)) dut_a (
    .clk_i    (clk),
    .reset_n_i(reset_n),
    .bus_if   (ifa.slave)
  );

  vanilla_core_trigger_window #(.num_ch_p(NCH), .max_depth_p(3), .count_width_p(CW)) dut_b (
    .clk_i    (clk),
    .reset_n_i(reset_n),
    .bus_if   (ifb.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] trig(input logic [2:0] f3, input int unsigned ch);
    return {7'b0, 5'(ch), 5'b0, f3, 5'b0, 7'b0001011};
  endfunction

  function automatic logic [31:0] cnt_exp(input int unsigned v);
    return CNT_EN ? 32'(v) : 32'h0;
  endfunction

  task automatic step(input int unsigned n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue_a(input logic [31:0] instr);
    ifa.instr_i   = instr;
    ifa.instr_v_i = 1'b1;
    step();
    ifa.instr_v_i = 1'b0;
  endtask

  task automatic issue_b(input logic [31:0] instr);
    ifb.instr_i   = instr;
    ifb.instr_v_i = 1'b1;
    step();
    ifb.instr_v_i = 1'b0;
  endtask

  initial begin
    ifa.instr_i = '0; ifa.instr_v_i = 1'b0; ifa.stall_i = 1'b0; ifa.leader_i = 1'b1;
    ifb.instr_i = '0; ifb.instr_v_i = 1'b0; ifb.stall_i = 1'b0; ifb.leader_i = 1'b0;

    // reset state
    step(2);
    check("rst_win",   32'(ifa.window_en_o), 32'h0);
    check("rst_start", 32'(ifa.toggle_start_o), 32'h0);
    check("rst_stop",  32'(ifa.toggle_stop_o), 32'h0);
    check("rst_ovf",   32'(ifa.overflow_o), 32'h0);
    check("rst_unf",   32'(ifa.underflow_o), 32'h0);
    check("rst_cnt0",  ifa.active_cycles_o[31:0], 32'h0);
    reset_n = 1'b1;
    step(2);

    // single window on ch1
    issue_a(trig(3'b000, 1));
    check("t1_win_open",   32'(ifa.window_en_o), 32'h2);
    check("t1_start_pre",  32'(ifa.toggle_start_o), 32'h0);
    step();
    check("t1_start_pulse", 32'(ifa.toggle_start_o), 32'h2);
    step();
    check("t1_start_done", 32'(ifa.toggle_start_o), 32'h0);
    step(2);
    issue_a(trig(3'b001, 1));
    check("t1_win_close",  32'(ifa.window_en_o), 32'h0);
    check("t1_stop_pre",   32'(ifa.toggle_stop_o), 32'h0);
    check("t1_cnt1",       ifa.active_cycles_o[63:32], cnt_exp(5));
    step();
    check("t1_stop_pulse", 32'(ifa.toggle_stop_o), 32'h2);
    step();
    check("t1_stop_done",  32'(ifa.toggle_stop_o), 32'h0);

    // nesting on ch0 with overflow and underflow
    ifa.instr_i   = trig(3'b000, 0);
    ifa.instr_v_i = 1'b1;
    step(3);
    check("t2_win_d3",  32'(ifa.window_en_o), 32'h1);
    check("t2_ovf_no",  32'(ifa.overflow_o), 32'h0);
    step();
    check("t2_ovf_set", 32'(ifa.overflow_o), 32'h1);
    check("t2_win_d3b", 32'(ifa.window_en_o), 32'h1);
    ifa.instr_i = trig(3'b001, 0);
    step(2);
    check("t2_win_d1",  32'(ifa.window_en_o), 32'h1);
    step();
    check("t2_win_d0",  32'(ifa.window_en_o), 32'h0);
    check("t2_unf_no",  32'(ifa.underflow_o), 32'h0);
    step();
    ifa.instr_v_i = 1'b0;
    check("t2_unf_set", 32'(ifa.underflow_o), 32'h1);
    check("t2_ovf_sticky", 32'(ifa.overflow_o), 32'h1);
    check("t2_cnt0",    ifa.active_cycles_o[31:0], cnt_exp(6));
    check("t2_cnt1_hold", ifa.active_cycles_o[63:32], cnt_exp(5));
    step(3);

    // start on ch2 held under stall
    ifa.instr_i   = trig(3'b000, 2);
    ifa.instr_v_i = 1'b1;
    ifa.stall_i   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t3_stalled", 32'(ifa.window_en_o), 32'h0);
    end
    ifa.stall_i = 1'b0;
    step();
    ifa.instr_v_i = 1'b0;
    check("t3_accepted", 32'(ifa.window_en_o), 32'h4);
    step();
    check("t3_held", 32'(ifa.window_en_o), 32'h4);
    issue_a(trig(3'b001, 2));
    check("t3_one_inc", 32'(ifa.window_en_o), 32'h0);
    check("t3_unf",     32'(ifa.underflow_o), 32'h1);
    check("t3_cnt2",    ifa.active_cycles_o[95:64], cnt_exp(2));
    step(3);

    // two cores share ch0; only the leader pulses
    issue_a(trig(3'b000, 0));
    step();
    check("t4_a_start",  32'(ifa.toggle_start_o), 32'h1);
    check("t4_b_start",  32'(ifb.toggle_start_o), 32'h0);
    issue_b(trig(3'b000, 0));
    check("t4_a_start_done", 32'(ifa.toggle_start_o), 32'h0);
    issue_a(trig(3'b001, 0));
    check("t4_a_closed", 32'(ifa.window_en_o), 32'h0);
    check("t4_b_open",   32'(ifb.window_en_o), 32'h1);
    step();
    check("t4_no_early_stop", 32'(ifa.toggle_stop_o), 32'h0);
    check("t4_no_restart",    32'(ifa.toggle_start_o), 32'h0);
    issue_b(trig(3'b001, 0));
    check("t4_b_closed", 32'(ifb.window_en_o), 32'h0);
    step();
    check("t4_a_stop",   32'(ifa.toggle_stop_o), 32'h1);
    check("t4_b_stop",   32'(ifb.toggle_stop_o), 32'h0);
    step();
    check("t4_a_stop_done", 32'(ifa.toggle_stop_o), 32'h0);
    step(2);

    // out-of-range channels are ignored
    issue_a(trig(3'b000, 7));
    issue_a(trig(3'b001, 7));
    issue_a(trig(3'b001, 4));
    check("t5_win", 32'(ifa.window_en_o), 32'h0);
    check("t5_ovf", 32'(ifa.overflow_o), 32'h1);
    check("t5_unf", 32'(ifa.underflow_o), 32'h1);
    step();
    check("t5_no_pulse", 32'(ifa.toggle_start_o), 32'h0);

    // async reset mid-window on ch3
    issue_a(trig(3'b000, 3));
    step(3);
    check("t6_open", 32'(ifa.window_en_o), 32'h8);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_rst_win",   32'(ifa.window_en_o), 32'h0);
    check("t6_rst_ovf",   32'(ifa.overflow_o), 32'h0);
    check("t6_rst_unf",   32'(ifa.underflow_o), 32'h0);
    check("t6_rst_start", 32'(ifa.toggle_start_o), 32'h0);
    check("t6_rst_cnt3",  ifa.active_cycles_o[127:96], 32'h0);
    check("t6_rst_cnt1",  ifa.active_cycles_o[63:32], 32'h0);
    step(2);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t6_no_stop", 32'(ifa.toggle_stop_o), 32'h0);
    end
    check("t6_cnt3_after", ifa.active_cycles_o[127:96], 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
